// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite bus bundle for the register slave: AW/W/B write channels and AR/R read channels.
// The slave modport is what axil_reg_slave consumes; master is for drivers and interconnect.
interface axil_reg_slave_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [2:0]              awprot;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [2:0]              arprot;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
    input  araddr, arvalid, arprot, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
    output araddr, arvalid, arprot, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register file: NUM_REGS word registers with byte strobes, read-only slots fed by
// hw_rd_data, SLVERR on out-of-range or read-only writes, and per-register access pulses.
module axil_reg_slave #(
  parameter int                             DATA_WIDTH  = 32,
  parameter int                             ADDR_WIDTH  = 4,
  parameter int                             NUM_REGS    = 4,
  parameter logic [NUM_REGS-1:0]            RO_MASK     = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  axil_reg_slave_if.slave                bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_rd_data,
  output logic [NUM_REGS-1:0]            wr_pulse,
  output logic [NUM_REGS-1:0]            rd_pulse
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_RESP } r_state_t;

  w_state_t w_state_reg, w_state_next;
  r_state_t r_state_reg, r_state_next;

  logic                  aw_done_reg, w_done_reg;
  logic [ADDR_WIDTH-1:0] awaddr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [STRB_W-1:0]     wstrb_reg;
  logic [1:0]            bresp_reg;
  logic [NUM_REGS-1:0]   wr_pulse_reg;

  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [1:0]            rresp_reg;
  logic [NUM_REGS-1:0]   rd_pulse_reg;

  logic                  aw_hs, w_hs, ar_hs, w_commit;
  logic [ADDR_WIDTH-1:0] w_addr_eff;
  logic [DATA_WIDTH-1:0] w_data_eff;
  logic [STRB_W-1:0]     w_strb_eff;
  logic [IDX_W-1:0]      w_idx, ar_idx;
  logic                  w_ok, r_ok;
  logic [DATA_WIDTH-1:0] r_mux;
  logic [NUM_REGS-1:0]   wr_sel, rd_sel;
  logic                  unused_bits;

  assign aw_hs  = bus.awvalid && bus.awready;
  assign w_hs   = bus.wvalid && bus.wready;
  assign ar_hs  = bus.arvalid && bus.arready;

  // A handshake completing this cycle bypasses its capture register so the commit is not delayed.
  assign w_addr_eff = aw_done_reg ? awaddr_reg : bus.awaddr;
  assign w_data_eff = w_done_reg  ? wdata_reg  : bus.wdata;
  assign w_strb_eff = w_done_reg  ? wstrb_reg  : bus.wstrb;
  assign w_idx      = w_addr_eff[ADDR_WIDTH-1:2];
  assign ar_idx     = bus.araddr[ADDR_WIDTH-1:2];
  assign w_commit   = (w_state_reg == W_IDLE) && (w_state_next == W_RESP);

  assign unused_bits = ^{bus.awprot, bus.arprot, w_addr_eff[1:0], bus.araddr[1:0]};

  // Write FSM: state register, next state, outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_state_reg <= W_IDLE;
    else     w_state_reg <= w_state_next;
  end

  always_comb begin
    w_state_next = w_state_reg;
    case (w_state_reg)
      W_IDLE: if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) w_state_next = W_RESP;
      W_RESP: if (bus.bready) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    case (w_state_reg)
      W_IDLE: begin
        bus.awready = !aw_done_reg;
        bus.wready  = !w_done_reg;
      end
      W_RESP:  bus.bvalid = 1'b1;
      default: ;
    endcase
  end

  // Read FSM: state register, next state, outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state_reg <= R_IDLE;
    else     r_state_reg <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state_reg;
    case (r_state_reg)
      R_IDLE:  if (ar_hs) r_state_next = R_RESP;
      R_RESP:  if (bus.rready) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    bus.arready = (r_state_reg == R_IDLE);
    bus.rvalid  = (r_state_reg == R_RESP);
  end

  // Index decode for both channels; unmatched indices stay invalid.
  always_comb begin
    w_ok  = 1'b0;
    r_ok  = 1'b0;
    r_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_idx == IDX_W'(i) && !RO_MASK[i]) w_ok = 1'b1;
      if (ar_idx == IDX_W'(i)) begin
        r_ok  = 1'b1;
        r_mux = RO_MASK[i] ? hw_rd_data[i*DATA_WIDTH +: DATA_WIDTH]
                           : reg_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_done_reg  <= 1'b0;
      w_done_reg   <= 1'b0;
      awaddr_reg   <= '0;
      wdata_reg    <= '0;
      wstrb_reg    <= '0;
      bresp_reg    <= RESP_OKAY;
      wr_pulse_reg <= '0;
    end else begin
      if (aw_hs) awaddr_reg <= bus.awaddr;
      if (w_hs) begin
        wdata_reg <= bus.wdata;
        wstrb_reg <= bus.wstrb;
      end
      aw_done_reg  <= w_commit ? 1'b0 : (aw_done_reg || aw_hs);
      w_done_reg   <= w_commit ? 1'b0 : (w_done_reg || w_hs);
      wr_pulse_reg <= wr_sel;
      if (w_commit) bresp_reg <= w_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Read data is sampled at the AR handshake, before any same-edge write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_reg    <= '0;
      rresp_reg    <= RESP_OKAY;
      rd_pulse_reg <= '0;
    end else begin
      rd_pulse_reg <= rd_sel;
      if (ar_hs) begin
        rdata_reg <= r_ok ? r_mux : '0;
        rresp_reg <= r_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_WIDTH-1:0] q_reg;

      assign wr_sel[gi] = w_commit && !RO_MASK[gi] && (w_idx == IDX_W'(gi));
      assign rd_sel[gi] = ar_hs && (ar_idx == IDX_W'(gi));
      assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = q_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q_reg <= RESET_VALUE[gi*DATA_WIDTH +: DATA_WIDTH];
        end else if (wr_sel[gi]) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (w_strb_eff[b]) q_reg[b*8 +: 8] <= w_data_eff[b*8 +: 8];
          end
        end
      end
    end
  endgenerate

  assign bus.bresp = bresp_reg;
  assign bus.rdata = rdata_reg;
  assign bus.rresp = rresp_reg;
  assign wr_pulse  = wr_pulse_reg;
  assign rd_pulse  = rd_pulse_reg;
endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave: 3 registers, reg 2 read-only, index 3 out of range.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_axil_reg_slave;
  localparam logic [95:0] RST_VAL = 96'h00000000_12345678_00000000;

  logic        clk;
  logic        rst;
  logic [95:0] reg_q;
  logic [95:0] hw_rd_data;
  logic [2:0]  wr_pulse;
  logic [2:0]  rd_pulse;
  logic [95:0] exp_q;
  int          n_cmp;
  int          n_fail;

  axil_reg_slave_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

  axil_reg_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(3),
    .RO_MASK(3'b100), .RESET_VALUE(RST_VAL)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .reg_q(reg_q),
    .hw_rd_data(hw_rd_data), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bus.awaddr = addr; bus.awvalid = 1'b1;
    bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
      n_fail++; $display("FAIL reset_ready got %b want 111", {bus.awready, bus.wready, bus.arready}); end
    n_cmp++; if ({bus.bvalid, bus.rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL reset_valid got %b want 00", {bus.bvalid, bus.rvalid}); end
    n_cmp++; if ({bus.bresp, bus.rresp} !== 4'b0000 || bus.rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_resp got %b/%b rdata %h want 0", bus.bresp, bus.rresp, bus.rdata); end
    n_cmp++; if ({wr_pulse, rd_pulse} !== 6'b0) begin
      n_fail++; $display("FAIL reset_pulse got %b/%b want 0", wr_pulse, rd_pulse); end
    n_cmp++; if (reg_q !== RST_VAL) begin
      n_fail++; $display("FAIL reset_regq got %h want %h", reg_q, RST_VAL); end
    $display("RESET reg_q=%h", reg_q);
  endtask

  task automatic test_write_same_cycle();
    @(posedge clk); #1 drive_write(4'h4, 32'hDEADBEEF, 4'hF); bus.bready = 1'b1;
    @(posedge clk); #1 bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    exp_q[63:32] = 32'hDEADBEEF;
    @(negedge clk);
    $display("WR addr=4 data=deadbeef bvalid=%b bresp=%b", bus.bvalid, bus.bresp);
    n_cmp++; if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) begin
      n_fail++; $display("FAIL wr_same_b got %b/%b want 1/00", bus.bvalid, bus.bresp); end
    n_cmp++; if (reg_q !== exp_q) begin
      n_fail++; $display("FAIL wr_same_regq got %h want %h", reg_q, exp_q); end
    n_cmp++; if (wr_pulse !== 3'b010) begin
      n_fail++; $display("FAIL wr_same_pulse got %b want 010", wr_pulse); end
    n_cmp++; if ({bus.awready, bus.wready} !== 2'b00) begin
      n_fail++; $display("FAIL wr_same_ready got %b want 00", {bus.awready, bus.wready}); end
    @(negedge clk);
    n_cmp++; if ({bus.bvalid, wr_pulse, bus.awready, bus.wready} !== 6'b0_000_11) begin
      n_fail++; $display("FAIL wr_same_after got %b want 000011", {bus.bvalid, wr_pulse, bus.awready, bus.wready}); end
  endtask

  task automatic test_w_first();
    @(posedge clk); #1 bus.wdata = 32'h11223344; bus.wstrb = 4'b0101; bus.wvalid = 1'b1;
    @(posedge clk); #1 bus.wvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++; if ({bus.bvalid, bus.awready, bus.wready} !== 3'b010) begin
        n_fail++; $display("FAIL wfirst_wait%0d got %b want 010", i, {bus.bvalid, bus.awready, bus.wready}); end
    end
    @(posedge clk); #1 bus.awaddr = 4'h0; bus.awvalid = 1'b1;
    @(posedge clk); #1 bus.awvalid = 1'b0;
    exp_q[31:0] = 32'h00220044;
    @(negedge clk);
    $display("WR addr=0 data=11223344 strb=0101 bvalid=%b bresp=%b", bus.bvalid, bus.bresp);
    n_cmp++; if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) begin
      n_fail++; $display("FAIL wfirst_b got %b/%b want 1/00", bus.bvalid, bus.bresp); end
    n_cmp++; if (reg_q !== exp_q) begin
      n_fail++; $display("FAIL wfirst_regq got %h want %h", reg_q, exp_q); end
    n_cmp++; if (wr_pulse !== 3'b001) begin
      n_fail++; $display("FAIL wfirst_pulse got %b want 001", wr_pulse); end
    @(negedge clk);
  endtask

  task automatic test_read_only();
    @(posedge clk); #1 drive_write(4'h8, 32'hFFFFFFFF, 4'hF);
    @(posedge clk); #1 bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge clk);
    $display("WR addr=8 (ro) bvalid=%b bresp=%b", bus.bvalid, bus.bresp);
    n_cmp++; if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b10) begin
      n_fail++; $display("FAIL ro_wr_b got %b/%b want 1/10", bus.bvalid, bus.bresp); end
    n_cmp++; if (reg_q !== exp_q || wr_pulse !== 3'b000) begin
      n_fail++; $display("FAIL ro_wr_state got %h/%b want %h/000", reg_q, wr_pulse, exp_q); end
    @(posedge clk); #1 bus.araddr = 4'h8; bus.arvalid = 1'b1; bus.rready = 1'b1;
    @(posedge clk); #1 bus.arvalid = 1'b0;
    @(negedge clk);
    $display("RD addr=8 rdata=%h rresp=%b", bus.rdata, bus.rresp);
    n_cmp++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hCAFE0001 || bus.rresp !== 2'b00) begin
      n_fail++; $display("FAIL ro_rd got %b/%h/%b want 1/cafe0001/00", bus.rvalid, bus.rdata, bus.rresp); end
    n_cmp++; if (rd_pulse !== 3'b100 || bus.arready !== 1'b0) begin
      n_fail++; $display("FAIL ro_rd_pulse got %b/%b want 100/0", rd_pulse, bus.arready); end
    @(negedge clk);
    n_cmp++; if ({bus.rvalid, rd_pulse, bus.arready} !== 5'b0_000_1) begin
      n_fail++; $display("FAIL ro_rd_after got %b want 00001", {bus.rvalid, rd_pulse, bus.arready}); end
  endtask

  task automatic test_invalid();
    @(posedge clk); #1 bus.araddr = 4'hC; bus.arvalid = 1'b1;
    @(posedge clk); #1 bus.arvalid = 1'b0;
    @(negedge clk);
    $display("RD addr=c rdata=%h rresp=%b", bus.rdata, bus.rresp);
    n_cmp++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h0 || bus.rresp !== 2'b10) begin
      n_fail++; $display("FAIL inv_rd got %b/%h/%b want 1/0/10", bus.rvalid, bus.rdata, bus.rresp); end
    n_cmp++; if (rd_pulse !== 3'b000) begin
      n_fail++; $display("FAIL inv_rd_pulse got %b want 000", rd_pulse); end
    @(posedge clk); #1 drive_write(4'hC, 32'h77777777, 4'hF);
    @(posedge clk); #1 bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge clk);
    $display("WR addr=c bvalid=%b bresp=%b", bus.bvalid, bus.bresp);
    n_cmp++; if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b10) begin
      n_fail++; $display("FAIL inv_wr_b got %b/%b want 1/10", bus.bvalid, bus.bresp); end
    n_cmp++; if (reg_q !== exp_q || wr_pulse !== 3'b000) begin
      n_fail++; $display("FAIL inv_wr_state got %h/%b want %h/000", reg_q, wr_pulse, exp_q); end
    @(negedge clk);
  endtask

  task automatic test_read_backpressure();
    @(posedge clk); #1 bus.araddr = 4'h5; bus.arvalid = 1'b1; bus.rready = 1'b0;
    @(posedge clk); #1 bus.arvalid = 1'b0;
    @(negedge clk);
    $display("RD addr=5 rdata=%h rresp=%b (held)", bus.rdata, bus.rresp);
    n_cmp++; if (rd_pulse !== 3'b010) begin
      n_fail++; $display("FAIL rbp_pulse got %b want 010", rd_pulse); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({bus.rvalid, bus.arready, bus.rresp} !== 4'b1000 || bus.rdata !== 32'hDEADBEEF) begin
        n_fail++; $display("FAIL rbp_hold%0d got %b%b/%b/%h want 1/0/00/deadbeef", i, bus.rvalid, bus.arready, bus.rresp, bus.rdata); end
      @(negedge clk);
    end
    n_cmp++; if (rd_pulse !== 3'b000) begin
      n_fail++; $display("FAIL rbp_pulse_once got %b want 000", rd_pulse); end
    @(posedge clk); #1 bus.rready = 1'b1;
    @(negedge clk); @(negedge clk);
    n_cmp++; if ({bus.rvalid, bus.arready} !== 2'b01) begin
      n_fail++; $display("FAIL rbp_release got %b want 01", {bus.rvalid, bus.arready}); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1 drive_write(4'h0, 32'hA0A0A0A0, 4'hF); bus.bready = 1'b0;
    @(posedge clk); #1 drive_write(4'h4, 32'h5A5A5A5A, 4'b1100);
    exp_q[31:0] = 32'hA0A0A0A0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if ({bus.bvalid, bus.bresp, bus.awready, bus.wready} !== 5'b1_00_00) begin
        n_fail++; $display("FAIL b2b_hold%0d got %b want 10000", i, {bus.bvalid, bus.bresp, bus.awready, bus.wready}); end
    end
    $display("WR addr=0 data=a0a0a0a0 held 5 cycles");
    @(posedge clk); #1 bus.bready = 1'b1;
    @(negedge clk); @(negedge clk);
    n_cmp++; if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011 || reg_q !== exp_q) begin
      n_fail++; $display("FAIL b2b_gap got %b/%h want 011/%h", {bus.bvalid, bus.awready, bus.wready}, reg_q, exp_q); end
    @(posedge clk); #1 bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    exp_q[63:32] = 32'h5A5ABEEF;
    @(negedge clk);
    $display("WR addr=4 data=5a5a5a5a strb=1100 bvalid=%b bresp=%b", bus.bvalid, bus.bresp);
    n_cmp++; if (bus.bvalid !== 1'b1 || reg_q !== exp_q || wr_pulse !== 3'b010) begin
      n_fail++; $display("FAIL b2b_second got %b/%h/%b want 1/%h/010", bus.bvalid, reg_q, wr_pulse, exp_q); end
    @(negedge clk);
  endtask

  task automatic test_concurrent();
    @(posedge clk); #1 drive_write(4'h0, 32'h01020304, 4'hF);
    bus.araddr = 4'h0; bus.arvalid = 1'b1;
    @(posedge clk); #1 bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    exp_q[31:0] = 32'h01020304;
    @(negedge clk);
    $display("WR+RD addr=0 rdata=%h reg0=%h", bus.rdata, reg_q[31:0]);
    n_cmp++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hA0A0A0A0) begin
      n_fail++; $display("FAIL conc_rd got %b/%h want 1/a0a0a0a0", bus.rvalid, bus.rdata); end
    n_cmp++; if (bus.bvalid !== 1'b1 || reg_q !== exp_q) begin
      n_fail++; $display("FAIL conc_wr got %b/%h want 1/%h", bus.bvalid, reg_q, exp_q); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1 bus.araddr = 4'h4; bus.arvalid = 1'b1; bus.rready = 1'b0;
    bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(posedge clk); #1 bus.arvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({bus.rvalid, bus.wready} !== 2'b10) begin
      n_fail++; $display("FAIL rstmid_pre got %b want 10", {bus.rvalid, bus.wready}); end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    $display("RESET mid-transaction reg_q=%h", reg_q);
    exp_q = RST_VAL;
    n_cmp++; if ({bus.rvalid, bus.bvalid, bus.awready, bus.wready, bus.arready} !== 5'b00111) begin
      n_fail++; $display("FAIL rstmid_flags got %b want 00111", {bus.rvalid, bus.bvalid, bus.awready, bus.wready, bus.arready}); end
    n_cmp++; if (reg_q !== exp_q) begin
      n_fail++; $display("FAIL rstmid_regq got %h want %h", reg_q, exp_q); end
    @(posedge clk); #1 rst = 1'b0; bus.rready = 1'b1;
    @(posedge clk); #1 bus.awaddr = 4'h0; bus.awvalid = 1'b1;
    @(posedge clk); #1 bus.awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.bvalid !== 1'b0 || reg_q !== exp_q) begin
        n_fail++; $display("FAIL rstmid_late%0d got %b/%h want 0/%h", i, bus.bvalid, reg_q, exp_q); end
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; exp_q = RST_VAL;
    rst = 1'b1;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.awprot = 3'b000;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arvalid = 1'b0; bus.arprot = 3'b000; bus.rready = 1'b0;
    hw_rd_data = {32'hCAFE0001, 32'h5555AAAA, 32'h33CC33CC};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_write_same_cycle();
    test_w_first();
    test_read_only();
    test_invalid();
    test_read_backpressure();
    test_back_to_back();
    test_concurrent();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
